dmem_arbiter: RTL and testbench

//  Shares the single-port word-addressed data memory between two requesters: port 0 is the

---
 rtl/dmem_pkg.sv | 22 ++
 rtl/dmem_arbiter_if.sv | 50 +++++
 rtl/dmem_arb_pick.sv | 23 ++
 rtl/dmem_arbiter.sv | 146 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory arbiter.
package dmem_pkg;

    localparam int unsigned IDX_W_DEF = 10;
    localparam int unsigned MEM_AW    = 32;

    // Owner of the read response due in the next cycle
    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_P0   = 2'd1,
        TAG_P1   = 2'd2
    } resp_tag_t;

    // Byte address -> word index; bits above the memory size wrap away
    function automatic logic [MEM_AW-1:0] word_index(input logic [MEM_AW-1:0] byte_addr,
                                                     input int unsigned       idx_w);
        logic [MEM_AW-1:0] mask;
        mask = (MEM_AW'(1) << idx_w) - MEM_AW'(1);
        return (byte_addr >> 2) & mask;
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester ports and DATA_MEMORY side of the data-memory arbiter.
interface dmem_arbiter_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
);
    logic          P0_REQ;
    logic          P0_WE;
    logic [AW-1:0] P0_ADDR;
    logic [DW-1:0] P0_WDATA;
    logic          P0_GNT;
    logic          P0_RVALID;
    logic [DW-1:0] P0_RDATA;
    logic          P0_ERR;

    logic          P1_REQ;
    logic          P1_WE;
    logic [AW-1:0] P1_ADDR;
    logic [DW-1:0] P1_WDATA;
    logic          P1_GNT;
    logic          P1_RVALID;
    logic [DW-1:0] P1_RDATA;
    logic          P1_ERR;

    logic [31:0]   MEM_ADDRESS;
    logic [DW-1:0] MEM_WDATA;
    logic          MEM_READ;
    logic          MEM_WRITE;
    logic [DW-1:0] MEM_RDATA;

    // Arbiter side
    modport slave (
        input  P0_REQ, P0_WE, P0_ADDR, P0_WDATA,
        output P0_GNT, P0_RVALID, P0_RDATA, P0_ERR,
        input  P1_REQ, P1_WE, P1_ADDR, P1_WDATA,
        output P1_GNT, P1_RVALID, P1_RDATA, P1_ERR,
        output MEM_ADDRESS, MEM_WDATA, MEM_READ, MEM_WRITE,
        input  MEM_RDATA
    );

    // Requesters and memory side
    modport master (
        output P0_REQ, P0_WE, P0_ADDR, P0_WDATA,
        input  P0_GNT, P0_RVALID, P0_RDATA, P0_ERR,
        output P1_REQ, P1_WE, P1_ADDR, P1_WDATA,
        input  P1_GNT, P1_RVALID, P1_RDATA, P1_ERR,
        input  MEM_ADDRESS, MEM_WDATA, MEM_READ, MEM_WRITE,
        output MEM_RDATA
    );

endinterface

// File: rtl/dmem_arb_pick.sv
// Two-way combinational picker: lone requester wins, prefer1 breaks ties.
module dmem_arb_pick (
    input  logic req0,
    input  logic req1,
    input  logic prefer1,
    output logic gnt0_c,
    output logic gnt1_c
);

    // One-hot grant selection
    always_comb begin
        gnt0_c = 1'b0;
        gnt1_c = 1'b0;
        if (req0 && req1) begin
            gnt1_c = prefer1;
            gnt0_c = !prefer1;
        end else begin
            gnt0_c = req0;
            gnt1_c = req1;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the MEM stage (port 0) and the
// loader (port 1). Default: fixed priority to port 0 with MAX_WAIT starvation
// guard. Define DMEM_ARB_ROUND_ROBIN_EN for round-robin on contention.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int unsigned AW       = 32,
    parameter int unsigned DW       = 32,
    parameter int unsigned IDX_W    = IDX_W_DEF,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic          CLK,
    input  logic          RESET,
    dmem_arbiter_if.slave bus
);

    logic          req0_c;
    logic          req1_c;
    logic          prefer1_c;
    logic          gnt0_c;
    logic          gnt1_c;
    logic          any_gnt_c;
    logic          aligned_c;
    logic          sel_we_c;
    logic [AW-1:0] sel_addr_c;
    logic [DW-1:0] sel_wdata_c;
    logic          mem_read_c;
    logic          mem_write_c;

    resp_tag_t     tag_q;
    resp_tag_t     tag_d;
    logic          err0_q;
    logic          err1_q;
    logic          err0_d;
    logic          err1_d;

    // No grants are issued while reset is held
    assign req0_c = bus.P0_REQ & ~RESET;
    assign req1_c = bus.P1_REQ & ~RESET;

    dmem_arb_pick u_pick (
        .req0    (req0_c),
        .req1    (req1_c),
        .prefer1 (prefer1_c),
        .gnt0_c  (gnt0_c),
        .gnt1_c  (gnt1_c)
    );

`ifdef DMEM_ARB_ROUND_ROBIN_EN
    logic rr_q;

    assign prefer1_c = rr_q;

    // Pointer favours the port that lost the last contended grant
    always_ff @(posedge CLK) begin
        if (RESET) begin
            rr_q <= 1'b0;
        end else if (req0_c && req1_c) begin
            rr_q <= gnt0_c;
        end
    end
`else
    localparam int unsigned CNT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);

    logic [CNT_W-1:0] starve_q;

    assign prefer1_c = (starve_q == CNT_W'(MAX_WAIT));

    // Count cycles port 1 is denied; saturates at MAX_WAIT because that forces a win
    always_ff @(posedge CLK) begin
        if (RESET) begin
            starve_q <= '0;
        end else if (gnt1_c) begin
            starve_q <= '0;
        end else if (req1_c) begin
            starve_q <= starve_q + CNT_W'(1);
        end
    end
`endif

    // Route the granted request onto the memory port
    always_comb begin
        any_gnt_c   = gnt0_c | gnt1_c;
        sel_we_c    = gnt1_c ? bus.P1_WE    : bus.P0_WE;
        sel_addr_c  = gnt1_c ? bus.P1_ADDR  : bus.P0_ADDR;
        sel_wdata_c = gnt1_c ? bus.P1_WDATA : bus.P0_WDATA;
        aligned_c   = (sel_addr_c[1:0] == 2'b00);
        mem_read_c  = any_gnt_c & aligned_c & ~sel_we_c;
        mem_write_c = any_gnt_c & aligned_c &  sel_we_c;
    end

    // Response pipeline registers (read owner tag and misalignment flags)
    always_ff @(posedge CLK) begin
        if (RESET) begin
            tag_q  <= TAG_NONE;
            err0_q <= 1'b0;
            err1_q <= 1'b0;
        end else begin
            tag_q  <= tag_d;
            err0_q <= err0_d;
            err1_q <= err1_d;
        end
    end

    // Next response state and all port outputs
    always_comb begin
        tag_d           = TAG_NONE;
        err0_d          = 1'b0;
        err1_d          = 1'b0;
        bus.P0_GNT      = gnt0_c;
        bus.P1_GNT      = gnt1_c;
        bus.P0_RVALID   = 1'b0;
        bus.P1_RVALID   = 1'b0;
        bus.P0_RDATA    = DW'(0);
        bus.P1_RDATA    = DW'(0);
        bus.P0_ERR      = 1'b0;
        bus.P1_ERR      = 1'b0;
        bus.MEM_ADDRESS = word_index(MEM_AW'(sel_addr_c), IDX_W);
        bus.MEM_WDATA   = sel_wdata_c;
        bus.MEM_READ    = mem_read_c;
        bus.MEM_WRITE   = mem_write_c;

        if (mem_read_c) begin
            tag_d = gnt1_c ? TAG_P1 : TAG_P0;
        end
        if (any_gnt_c && !aligned_c) begin
            err0_d = gnt0_c;
            err1_d = gnt1_c;
        end

        // A response already in flight is dropped when reset is applied
        if (!RESET) begin
            bus.P0_RVALID = (tag_q == TAG_P0);
            bus.P1_RVALID = (tag_q == TAG_P1);
            bus.P0_ERR    = err0_q;
            bus.P1_ERR    = err1_q;
            if (tag_q == TAG_P0) begin
                bus.P0_RDATA = bus.MEM_RDATA;
            end
            if (tag_q == TAG_P1) begin
                bus.P1_RDATA = bus.MEM_RDATA;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter with a synchronous-read memory model
// and a response scoreboard. Honours DMEM_ARB_ROUND_ROBIN_EN.
module tb_dmem_arbiter;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;

    dmem_arbiter_if #(.AW(32), .DW(32)) bus ();

    dmem_arbiter #(
        .AW       (32),
        .DW       (32),
        .IDX_W    (10),
        .MAX_WAIT (4)
    ) dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // DATA_MEMORY model: write at the edge, read data one cycle later
    logic [31:0] dmem [1024];
    logic [31:0] ref_mem [1024];
    logic [31:0] mem_rdata_q = 32'h0;

    always @(posedge clk) begin
        if (bus.MEM_WRITE) dmem[bus.MEM_ADDRESS[9:0]] <= bus.MEM_WDATA;
        if (bus.MEM_READ)  mem_rdata_q <= dmem[bus.MEM_ADDRESS[9:0]];
    end

    assign bus.MEM_RDATA = mem_rdata_q;

    typedef struct {
        int          port;
        bit          err;
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t sb[$];
    bit   pend0 = 1'b0;
    bit   pend1 = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int p, input logic req, input logic we,
                         input logic [31:0] a, input logic [31:0] d);
        if (p == 0) begin
            bus.P0_REQ = req; bus.P0_WE = we; bus.P0_ADDR = a; bus.P0_WDATA = d;
        end else begin
            bus.P1_REQ = req; bus.P1_WE = we; bus.P1_ADDR = a; bus.P1_WDATA = d;
        end
    endtask

    // Pop and compare one response seen on port p
    task automatic resp(input int p, input logic rv, input logic er, input logic [31:0] rd);
        exp_t e;
        if (rv || er) begin
            if (sb.size() == 0) begin
                chk($sformatf("p%0d_unexpected_resp", p), {30'b0, rv, er}, 32'h0);
            end else begin
                e = sb.pop_front();
                chk($sformatf("p%0d_resp_port", p), p, e.port);
                chk($sformatf("p%0d_resp_err", p), er, e.err);
                chk($sformatf("p%0d_resp_rvalid", p), rv, !e.err);
                if (!e.err) chk($sformatf("p%0d_resp_rdata", p), rd, e.data);
                chk($sformatf("p%0d_resp_cycle", p), cyc, e.due);
            end
        end
    endtask

    // Check memory-side drive for a grant and record the expected response
    task automatic grant(input int p, input logic g, input logic we,
                         input logic [31:0] a, input logic [31:0] d);
        exp_t       e;
        logic [9:0] idx;
        if (g) begin
            idx    = a[11:2];
            e.port = p;
            e.due  = cyc + 1;
            e.data = 32'h0;
            if (a[1:0] != 2'b00) begin
                chk("misaligned_mem_read", bus.MEM_READ, 1'b0);
                chk("misaligned_mem_write", bus.MEM_WRITE, 1'b0);
                e.err = 1'b1;
                sb.push_back(e);
            end else begin
                chk("mem_address", bus.MEM_ADDRESS, {22'b0, idx});
                chk("mem_read", bus.MEM_READ, !we);
                chk("mem_write", bus.MEM_WRITE, we);
                if (we) begin
                    chk("mem_wdata", bus.MEM_WDATA, d);
                    ref_mem[idx] = d;
                end else begin
                    e.err  = 1'b0;
                    e.data = ref_mem[idx];
                    sb.push_back(e);
                end
            end
        end
    endtask

    // Protocol monitor and scoreboard, sampled mid-cycle
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            pend0 = 1'b0;
            pend1 = 1'b0;
        end else begin
            chk("both_rvalid", bus.P0_RVALID & bus.P1_RVALID, 1'b0);
            chk("both_gnt", bus.P0_GNT & bus.P1_GNT, 1'b0);
            chk("read_and_write", bus.MEM_READ & bus.MEM_WRITE, 1'b0);
            resp(0, bus.P0_RVALID, bus.P0_ERR, bus.P0_RDATA);
            resp(1, bus.P1_RVALID, bus.P1_ERR, bus.P1_RDATA);
            if (sb.size() > 0) chk("resp_overdue", sb[0].due < cyc, 1'b0);
            if (pend0) chk("p0_req_dropped_before_gnt", bus.P0_REQ, 1'b1);
            if (pend1) chk("p1_req_dropped_before_gnt", bus.P1_REQ, 1'b1);
            grant(0, bus.P0_GNT, bus.P0_WE, bus.P0_ADDR, bus.P0_WDATA);
            grant(1, bus.P1_GNT, bus.P1_WE, bus.P1_ADDR, bus.P1_WDATA);
            pend0 = bus.P0_REQ && !bus.P0_GNT;
            pend1 = bus.P1_REQ && !bus.P1_GNT;
        end
    end

    // Hold a request until granted; report the memory drive seen at the grant
    task automatic issue(input int p, input logic we, input logic [31:0] a, input logic [31:0] d,
                         output logic [31:0] ma, output logic mr, output logic mw);
        int w;
        w = 0;
        drive(p, 1'b1, we, a, d);
        forever begin
            @(negedge clk);
            if ((p == 0) ? bus.P0_GNT : bus.P1_GNT) break;
            w++;
            if (w > 20) begin
                chk($sformatf("p%0d_grant_timeout", p), (p == 0) ? bus.P0_GNT : bus.P1_GNT, 1'b1);
                break;
            end
        end
        ma = bus.MEM_ADDRESS;
        mr = bus.MEM_READ;
        mw = bus.MEM_WRITE;
        @(posedge clk);
        #1;
        drive(p, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic idle_outputs(input string tag);
        chk({tag, "_p0_gnt"}, bus.P0_GNT, 1'b0);
        chk({tag, "_p1_gnt"}, bus.P1_GNT, 1'b0);
        chk({tag, "_p0_rvalid"}, bus.P0_RVALID, 1'b0);
        chk({tag, "_p1_rvalid"}, bus.P1_RVALID, 1'b0);
        chk({tag, "_p0_err"}, bus.P0_ERR, 1'b0);
        chk({tag, "_p1_err"}, bus.P1_ERR, 1'b0);
        chk({tag, "_p0_rdata"}, bus.P0_RDATA, 32'h0);
        chk({tag, "_p1_rdata"}, bus.P1_RDATA, 32'h0);
        chk({tag, "_mem_read"}, bus.MEM_READ, 1'b0);
        chk({tag, "_mem_write"}, bus.MEM_WRITE, 1'b0);
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1);
    end

    initial begin
        logic [31:0] ma;
        logic        mr;
        logic        mw;
        logic        exp1;
        int          w;

        for (int i = 0; i < 1024; i++) begin
            dmem[i]    = 32'h0;
            ref_mem[i] = 32'h0;
        end
        rst = 1'b1;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        drive(0, 1'b1, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b1, 1'b0, 32'h4, 32'h0);
        @(negedge clk);
        idle_outputs("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        idle_outputs("post_reset");

        // Write then read back through port 0
        issue(0, 1'b1, 32'h10, 32'hCAFE0001, ma, mr, mw);
        chk("t1_wr_addr", ma, 32'd4);
        chk("t1_wr_memwrite", mw, 1'b1);
        chk("t1_wr_memread", mr, 1'b0);
        issue(0, 1'b0, 32'h10, 32'h0, ma, mr, mw);
        chk("t1_rd_addr", ma, 32'd4);
        chk("t1_rd_memread", mr, 1'b1);
        @(negedge clk);
        chk("t1_rvalid", bus.P0_RVALID, 1'b1);
        chk("t1_rdata", bus.P0_RDATA, 32'hCAFE0001);
        @(posedge clk);
        #1;

        // Continuous contention on reads
        drive(0, 1'b1, 1'b0, 32'h10, 32'h0);
        drive(1, 1'b1, 1'b0, 32'h14, 32'h0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
`ifdef DMEM_ARB_ROUND_ROBIN_EN
            exp1 = (i % 2 == 1);
`else
            exp1 = (i % 5 == 4);
`endif
            chk($sformatf("contend_p1_gnt_%0d", i), bus.P1_GNT, exp1);
            chk($sformatf("contend_p0_gnt_%0d", i), bus.P0_GNT, !exp1);
            @(posedge clk);
            #1;
        end
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (!bus.P0_GNT && w < 10);
        chk("contend_p0_final_gnt", bus.P0_GNT, 1'b1);
        @(posedge clk);
        #1;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        #1;

        // Upper address bits wrap within the 1024-word memory
        issue(0, 1'b1, 32'h0000_1010, 32'hBEEF0002, ma, mr, mw);
        chk("wrap_wr_addr", ma, 32'd4);
        issue(0, 1'b0, 32'hFFFF_FFFC, 32'h0, ma, mr, mw);
        chk("wrap_top_addr", ma, 32'h3FF);
        issue(0, 1'b0, 32'h10, 32'h0, ma, mr, mw);
        @(negedge clk);
        chk("wrap_rdata", bus.P0_RDATA, 32'hBEEF0002);
        @(posedge clk);
        #1;

        // Misaligned accesses raise ERR and leave memory untouched
        issue(1, 1'b1, 32'h4, 32'h12345678, ma, mr, mw);
        chk("t4_wr_addr", ma, 32'd1);
        issue(1, 1'b0, 32'h7, 32'h0, ma, mr, mw);
        chk("t4_mis_rd_memread", mr, 1'b0);
        @(negedge clk);
        chk("t4_p1_err", bus.P1_ERR, 1'b1);
        chk("t4_p1_rvalid", bus.P1_RVALID, 1'b0);
        @(posedge clk);
        #1;
        issue(1, 1'b1, 32'h5, 32'h0000DEAD, ma, mr, mw);
        chk("t4_mis_wr_memwrite", mw, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("t4_mem_unchanged", dmem[1], 32'h12345678);
        issue(1, 1'b0, 32'h4, 32'h0, ma, mr, mw);
        @(negedge clk);
        chk("t4_rdata", bus.P1_RDATA, 32'h12345678);
        @(posedge clk);
        #1;

        // Back-to-back reads from different owners
        issue(0, 1'b0, 32'h0, 32'h0, ma, mr, mw);
        issue(1, 1'b0, 32'h4, 32'h0, ma, mr, mw);
        @(negedge clk);
        chk("t5_p1_rvalid", bus.P1_RVALID, 1'b1);
        chk("t5_p0_rvalid", bus.P0_RVALID, 1'b0);
        chk("t5_p1_rdata", bus.P1_RDATA, 32'h12345678);
        @(posedge clk);
        #1;

        // Reset right after a read grant drops the response
        issue(0, 1'b0, 32'h10, 32'h0, ma, mr, mw);
        rst = 1'b1;
        @(negedge clk);
        idle_outputs("t6_in_reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            idle_outputs($sformatf("t6_after_%0d", i));
        end

        @(posedge clk);
        #1;
        chk("scoreboard_empty", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
